// File: rtl/dma_write_block.sv
// DMA write engine: queues write commands, splits each into Avalon-MM bursts
// of at most MAX_BURST_BEATS beats and streams 256-bit beats from the DMA
// data FIFO onto the write master. A partial final 32-byte beat gets a
// narrowed byteenable.
module dma_write_block #(
  parameter int MAX_BURST_BEATS = 256,  // 1..2047
  parameter int CMD_FIFO_DEPTH  = 32    // power of 2, >= 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dma_wr_fifo_command_req_i,
  input  logic [15:0]  dma_wr_bytes_to_transfer_i,
  input  logic [31:0]  dma_wr_addr_i,
  output logic         dma_wr_fifo_full_o,
  input  logic [255:0] dma_wr_data_i,
  input  logic         dma_wr_data_empty_i,
  output logic         dma_wr_data_rdreq_o,
  output logic [31:0]  wr_master_addr_o,
  output logic [10:0]  wr_master_bcount_o,
  output logic         wr_master_write_o,
  output logic [255:0] wr_master_data_o,
  output logic [31:0]  wr_master_byteenable_o,
  input  logic         wr_master_wait_req_i,
  output logic         dma_wr_done_o,
  output logic         dma_wr_busy_o
);

  localparam int              PTR_W         = $clog2(CMD_FIFO_DEPTH);
  localparam logic [PTR_W:0]  FIFO_FULL_CNT = (PTR_W + 1)'(CMD_FIFO_DEPTH);
  localparam logic [11:0]     MAX_BEATS     = 12'(MAX_BURST_BEATS);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, LD_CMD, SETUP, BURST, NEXT, DONE
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] bytes;
  } cmd_t;

  // Command FIFO
  cmd_t             cmd_mem_q [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             cmd_push, cmd_pop, fifo_empty, fifo_full;

  // Transfer engine
  state_e       state_q, state_d;
  cmd_t         cmd_q, cmd_d;
  logic [31:0]  cur_addr_q, cur_addr_d;
  logic [11:0]  remaining_q, remaining_d;
  logic [4:0]   tail_q, tail_d;
  logic [11:0]  burst_beats_q, burst_beats_d;
  logic [11:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0]  m_addr_q, m_addr_d;
  logic [10:0]  m_bcount_q, m_bcount_d;

  logic         in_burst, beat_accept, last_beat_of_cmd;
  logic [31:0]  tail_be;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign cmd_push   = dma_wr_fifo_command_req_i & ~fifo_full;
  assign cmd_pop    = (state_q == RD_CMD);

  // Command FIFO pointer and occupancy next-state
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (cmd_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (cmd_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({cmd_push, cmd_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Command FIFO storage write
  // NOTE: storage is not reset; occupancy is, and no entry is read unless it was written.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[wr_ptr_q] <= '{addr: dma_wr_addr_i, bytes: dma_wr_bytes_to_transfer_i};
  end

  // Command FIFO pointer registers
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Burst handshake: write follows data availability, a beat moves on write & ~waitrequest
  assign in_burst            = (state_q == BURST);
  assign wr_master_write_o   = in_burst & ~dma_wr_data_empty_i;
  assign beat_accept         = wr_master_write_o & ~wr_master_wait_req_i;
  assign dma_wr_data_rdreq_o = beat_accept;
  assign wr_master_data_o    = in_burst ? dma_wr_data_i : '0;

  // Only the final beat of the final burst carries a partial-beat tail
  assign tail_be          = (32'd1 << tail_q) - 32'd1;
  assign last_beat_of_cmd = (remaining_q == burst_beats_q) &&
                            (beat_cnt_q == burst_beats_q - 12'd1);
  assign wr_master_byteenable_o = !in_burst ? '0 :
                                  (last_beat_of_cmd && (tail_q != '0)) ? tail_be : '1;

  assign wr_master_addr_o   = m_addr_q;
  assign wr_master_bcount_o = m_bcount_q;
  assign dma_wr_fifo_full_o = fifo_full;
  assign dma_wr_done_o      = (state_q == DONE);
  assign dma_wr_busy_o      = (state_q != IDLE);

  // Transfer FSM next-state: command fetch, burst splitting and address stepping
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    tail_d        = tail_q;
    burst_beats_d = burst_beats_q;
    beat_cnt_d    = beat_cnt_q;
    m_addr_d      = m_addr_q;
    m_bcount_d    = m_bcount_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = RD_CMD;
      end
      RD_CMD: begin
        cmd_d   = cmd_mem_q[rd_ptr_q];
        state_d = LD_CMD;
      end
      LD_CMD: begin
        cur_addr_d  = cmd_q.addr;
        remaining_d = {1'b0, cmd_q.bytes[15:5]} + {11'd0, |cmd_q.bytes[4:0]};
        tail_d      = cmd_q.bytes[4:0];
        state_d     = (remaining_d == '0) ? DONE : SETUP;
      end
      SETUP: begin
        burst_beats_d = (remaining_q > MAX_BEATS) ? MAX_BEATS : remaining_q;
        m_addr_d      = cur_addr_q;
        m_bcount_d    = burst_beats_d[10:0];
        beat_cnt_d    = '0;
        state_d       = BURST;
      end
      BURST: begin
        if (beat_accept) begin
          beat_cnt_d = beat_cnt_q + 12'd1;
          if (beat_cnt_q == burst_beats_q - 12'd1) state_d = NEXT;
        end
      end
      NEXT: begin
        cur_addr_d  = cur_addr_q + {15'd0, burst_beats_q, 5'd0};
        remaining_d = remaining_q - burst_beats_q;
        state_d     = (remaining_d == '0) ? DONE : SETUP;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transfer FSM registers; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      tail_q        <= '0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      m_addr_q      <= '0;
      m_bcount_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      tail_q        <= tail_d;
      burst_beats_q <= burst_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      m_addr_q      <= m_addr_d;
      m_bcount_q    <= m_bcount_d;
    end
  end

endmodule

// File: tb/tb_dma_write_block.sv
// Bench for dma_write_block: table of single-command transfers plus directed
// sequences for start latency, stalls, command FIFO overflow and mid-burst reset.
module tb_dma_write_block;

  logic         clk = 1'b0;
  logic         reset;
  logic         dma_wr_fifo_command_req_i;
  logic [15:0]  dma_wr_bytes_to_transfer_i;
  logic [31:0]  dma_wr_addr_i;
  logic         dma_wr_fifo_full_o;
  logic [255:0] dma_wr_data_i;
  logic         dma_wr_data_empty_i;
  logic         dma_wr_data_rdreq_o;
  logic [31:0]  wr_master_addr_o;
  logic [10:0]  wr_master_bcount_o;
  logic         wr_master_write_o;
  logic [255:0] wr_master_data_o;
  logic [31:0]  wr_master_byteenable_o;
  logic         wr_master_wait_req_i;
  logic         dma_wr_done_o;
  logic         dma_wr_busy_o;

  always #5 clk = ~clk;

  dma_write_block #(.MAX_BURST_BEATS(256), .CMD_FIFO_DEPTH(32)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .dma_wr_fifo_command_req_i  (dma_wr_fifo_command_req_i),
    .dma_wr_bytes_to_transfer_i (dma_wr_bytes_to_transfer_i),
    .dma_wr_addr_i              (dma_wr_addr_i),
    .dma_wr_fifo_full_o         (dma_wr_fifo_full_o),
    .dma_wr_data_i              (dma_wr_data_i),
    .dma_wr_data_empty_i        (dma_wr_data_empty_i),
    .dma_wr_data_rdreq_o        (dma_wr_data_rdreq_o),
    .wr_master_addr_o           (wr_master_addr_o),
    .wr_master_bcount_o         (wr_master_bcount_o),
    .wr_master_write_o          (wr_master_write_o),
    .wr_master_data_o           (wr_master_data_o),
    .wr_master_byteenable_o     (wr_master_byteenable_o),
    .wr_master_wait_req_i       (wr_master_wait_req_i),
    .dma_wr_done_o              (dma_wr_done_o),
    .dma_wr_busy_o              (dma_wr_busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Data FIFO model and transfer monitor state
  logic [255:0] data_q [$];
  int           next_seq = 0;
  int           exp_seq  = 0;
  bit           stall_wait  = 1'b0;
  bit           stall_empty = 1'b0;

  int          n_beats, n_done, n_data_err, n_hs_err, n_stable_err, n_partial;
  logic [31:0] last_be;
  bit          in_burst;
  int          beat_in_burst;
  logic [31:0] cur_addr;
  logic [10:0] cur_cnt;
  logic [31:0] b_addr [$];
  logic [10:0] b_cnt  [$];

  function automatic logic [255:0] make_word(input int seq);
    logic [31:0] s;
    s = 32'(seq);
    return {{7{s ^ 32'hC3A5_5A3C}}, s};
  endfunction

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      data_q.push_back(make_word(next_seq));
      next_seq++;
    end
  endtask

  task automatic flush_data();
    data_q.delete();
    exp_seq = next_seq;
  endtask

  task automatic clear_stats();
    n_beats = 0; n_done = 0; n_data_err = 0; n_hs_err = 0;
    n_stable_err = 0; n_partial = 0; last_be = '0;
    in_burst = 1'b0; beat_in_burst = 0; cur_addr = '0; cur_cnt = '0;
    b_addr.delete(); b_cnt.delete();
  endtask

  // One clock: drive data-FIFO/slave inputs at negedge, sample just after
  task automatic cycle();
    @(negedge clk);
    dma_wr_data_empty_i  = (data_q.size() == 0) || stall_empty;
    dma_wr_data_i        = (data_q.size() != 0) ? data_q[0] : '0;
    wr_master_wait_req_i = stall_wait;
    #1;
    if (dma_wr_done_o === 1'b1) n_done++;
    if (dma_wr_data_rdreq_o !== (wr_master_write_o & ~wr_master_wait_req_i)) n_hs_err++;
    if (wr_master_write_o === 1'b1 && dma_wr_data_empty_i) n_hs_err++;
    if (in_burst && (wr_master_addr_o !== cur_addr || wr_master_bcount_o !== cur_cnt))
      n_stable_err++;
    if (wr_master_write_o === 1'b1 && !in_burst) begin
      in_burst      = 1'b1;
      beat_in_burst = 0;
      cur_addr      = wr_master_addr_o;
      cur_cnt       = wr_master_bcount_o;
      b_addr.push_back(cur_addr);
      b_cnt.push_back(cur_cnt);
    end
    if (dma_wr_data_rdreq_o === 1'b1) begin
      if (data_q.size() == 0) n_data_err++;
      else begin
        if (wr_master_data_o !== data_q[0]) n_data_err++;
        if (wr_master_data_o[31:0] !== 32'(exp_seq)) n_data_err++;
        exp_seq++;
        void'(data_q.pop_front());
      end
      if (wr_master_byteenable_o !== 32'hFFFF_FFFF) n_partial++;
      last_be = wr_master_byteenable_o;
      n_beats++;
      beat_in_burst++;
      if (beat_in_burst == int'(cur_cnt)) in_burst = 1'b0;
    end
  endtask

  task automatic push_cmd(input logic [15:0] bytes, input logic [31:0] addr);
    dma_wr_fifo_command_req_i  = 1'b1;
    dma_wr_bytes_to_transfer_i = bytes;
    dma_wr_addr_i              = addr;
    cycle();
    dma_wr_fifo_command_req_i  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      cycle();
      k++;
    end
  endtask

  typedef struct {
    int          bytes;
    logic [31:0] addr;
    int          beats;
    int          bursts;
    logic [31:0] first_addr;
    logic [10:0] first_cnt;
    logic [31:0] last_addr;
    logic [10:0] last_cnt;
    logic [31:0] last_be;
    int          partial;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          b0, wcnt, aerr;
    logic [31:0] exp_a;
    logic        w_seen [5];
    logic        busy_seen [5];

    vecs[0] = '{64,    32'h0000_1000, 2,    1, 32'h1000,  11'd2,   32'h1000,  11'd2,   32'hFFFF_FFFF, 0};
    vecs[1] = '{100,   32'h0000_2000, 4,    1, 32'h2000,  11'd4,   32'h2000,  11'd4,   32'h0000_000F, 1};
    vecs[2] = '{40000, 32'h0000_0000, 1250, 5, 32'h0,     11'd256, 32'h8000,  11'd226, 32'hFFFF_FFFF, 0};
    vecs[3] = '{32,    32'h0000_0040, 1,    1, 32'h40,    11'd1,   32'h40,    11'd1,   32'hFFFF_FFFF, 0};
    vecs[4] = '{1,     32'h0000_0080, 1,    1, 32'h80,    11'd1,   32'h80,    11'd1,   32'h0000_0001, 1};
    vecs[5] = '{8223,  32'h0001_0000, 257,  2, 32'h10000, 11'd256, 32'h12000, 11'd1,   32'h7FFF_FFFF, 1};
    vecs[6] = '{65535, 32'h0000_0000, 2048, 8, 32'h0,     11'd256, 32'hE000,  11'd256, 32'h7FFF_FFFF, 1};
    vecs[7] = '{0,     32'h0000_0A00, 0,    0, 32'h0,     11'd0,   32'h0,     11'd0,   32'h0,         0};

    reset                      = 1'b1;
    dma_wr_fifo_command_req_i  = 1'b0;
    dma_wr_bytes_to_transfer_i = '0;
    dma_wr_addr_i              = '0;
    dma_wr_data_i              = '0;
    dma_wr_data_empty_i        = 1'b1;
    wr_master_wait_req_i       = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) cycle();
    check("rst write",  64'(wr_master_write_o), 64'd0);
    check("rst rdreq",  64'(dma_wr_data_rdreq_o), 64'd0);
    check("rst done",   64'(dma_wr_done_o), 64'd0);
    check("rst busy",   64'(dma_wr_busy_o), 64'd0);
    check("rst full",   64'(dma_wr_fifo_full_o), 64'd0);
    check("rst addr",   64'(wr_master_addr_o), 64'd0);
    check("rst bcount", 64'(wr_master_bcount_o), 64'd0);
    reset = 1'b0;
    cycle();

    // Start latency: IDLE -> RD_CMD -> LD_CMD -> SETUP -> BURST
    clear_stats();
    preload(2);
    push_cmd(16'd64, 32'h1000);
    check("lat busy before pop", 64'(dma_wr_busy_o), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      w_seen[k]    = wr_master_write_o;
      busy_seen[k] = dma_wr_busy_o;
    end
    check("lat busy at RD_CMD", 64'(busy_seen[1]), 64'd1);
    check("lat write c1", 64'(w_seen[1]), 64'd0);
    check("lat write c2", 64'(w_seen[2]), 64'd0);
    check("lat write c3", 64'(w_seen[3]), 64'd0);
    check("lat write c4", 64'(w_seen[4]), 64'd1);
    wait_done(1, 100);
    repeat (4) cycle();
    check("lat done", 64'(n_done), 64'd1);
    check("lat beats", 64'(n_beats), 64'd2);

    // Table of single-command transfers with preloaded data
    for (int i = 0; i < 8; i++) begin
      clear_stats();
      preload(vecs[i].beats);
      push_cmd(16'(vecs[i].bytes), vecs[i].addr);
      wait_done(1, vecs[i].beats * 2 + 100);
      repeat (8) cycle();
      check($sformatf("v%0d done", i),   64'(n_done), 64'd1);
      check($sformatf("v%0d beats", i),  64'(n_beats), 64'(vecs[i].beats));
      check($sformatf("v%0d bursts", i), 64'(b_addr.size()), 64'(vecs[i].bursts));
      if (b_addr.size() > 0) begin
        check($sformatf("v%0d first addr", i), 64'(b_addr[0]), 64'(vecs[i].first_addr));
        check($sformatf("v%0d first bcount", i), 64'(b_cnt[0]), 64'(vecs[i].first_cnt));
        check($sformatf("v%0d last addr", i), 64'(b_addr[b_addr.size()-1]), 64'(vecs[i].last_addr));
        check($sformatf("v%0d last bcount", i), 64'(b_cnt[b_cnt.size()-1]), 64'(vecs[i].last_cnt));
        aerr = 0;
        for (int j = 1; j < b_addr.size(); j++) begin
          exp_a = b_addr[j-1] + {16'd0, b_cnt[j-1], 5'd0};
          if (b_addr[j] !== exp_a) aerr++;
        end
        check($sformatf("v%0d burst addr step", i), 64'(aerr), 64'd0);
      end
      if (n_beats > 0) check($sformatf("v%0d last be", i), 64'(last_be), 64'(vecs[i].last_be));
      check($sformatf("v%0d partial beats", i), 64'(n_partial), 64'(vecs[i].partial));
      check($sformatf("v%0d handshake", i), 64'(n_hs_err), 64'd0);
      check($sformatf("v%0d data", i), 64'(n_data_err), 64'd0);
      check($sformatf("v%0d addr/bcount hold", i), 64'(n_stable_err), 64'd0);
      check($sformatf("v%0d data fifo drained", i), 64'(data_q.size()), 64'd0);
      check($sformatf("v%0d busy after", i), 64'(dma_wr_busy_o), 64'd0);
    end

    // Waitrequest stall then data-FIFO underrun mid-burst
    clear_stats();
    preload(8);
    push_cmd(16'd256, 32'h3000);
    begin
      int k;
      k = 0;
      while (n_beats < 2 && k < 50) begin cycle(); k++; end
    end
    check("stall reached beat 2", 64'(n_beats >= 2), 64'd1);
    b0 = n_beats;
    stall_wait = 1'b1;
    wcnt = 0;
    repeat (5) begin cycle(); if (wr_master_write_o === 1'b1) wcnt++; end
    check("stall wait no beats", 64'(n_beats), 64'(b0));
    check("stall wait write held", 64'(wcnt), 64'd5);
    stall_wait  = 1'b0;
    stall_empty = 1'b1;
    wcnt = 0;
    repeat (3) begin cycle(); if (wr_master_write_o === 1'b1) wcnt++; end
    check("stall empty no beats", 64'(n_beats), 64'(b0));
    check("stall empty write low", 64'(wcnt), 64'd0);
    stall_empty = 1'b0;
    wait_done(1, 100);
    repeat (4) cycle();
    check("stall done", 64'(n_done), 64'd1);
    check("stall beats", 64'(n_beats), 64'd8);
    check("stall bursts", 64'(b_addr.size()), 64'd1);
    check("stall handshake", 64'(n_hs_err), 64'd0);
    check("stall data order", 64'(n_data_err), 64'd0);
    check("stall addr/bcount hold", 64'(n_stable_err), 64'd0);
    check("stall fifo drained", 64'(data_q.size()), 64'd0);

    // Command FIFO overflow while the engine is parked on an empty data FIFO
    clear_stats();
    push_cmd(16'd32, 32'h100);
    repeat (4) cycle();
    check("full engine parked", 64'(dma_wr_busy_o), 64'd1);
    for (int i = 0; i < 32; i++) begin
      push_cmd((i == 4) ? 16'd0 : 16'd32, 32'h200 + 32'(i * 32));
      if (i == 30) check("full not yet at 31", 64'(dma_wr_fifo_full_o), 64'd0);
      if (i == 31) check("full at 32", 64'(dma_wr_fifo_full_o), 64'd1);
    end
    push_cmd(16'd64, 32'hF000);
    check("full after dropped push", 64'(dma_wr_fifo_full_o), 64'd1);
    preload(40);
    wait_done(33, 3000);
    repeat (20) cycle();
    check("full done pulses", 64'(n_done), 64'd33);
    check("full beats", 64'(n_beats), 64'd32);
    check("full data left", 64'(data_q.size()), 64'd8);
    check("full cleared", 64'(dma_wr_fifo_full_o), 64'd0);
    check("full busy after", 64'(dma_wr_busy_o), 64'd0);
    check("full handshake", 64'(n_hs_err), 64'd0);
    check("full data", 64'(n_data_err), 64'd0);

    // Reset during beat 3 of an 8-beat burst, with a second command queued
    flush_data();
    clear_stats();
    preload(8);
    push_cmd(16'd256, 32'h3000);
    push_cmd(16'd32, 32'h4000);
    begin
      int k;
      k = 0;
      while (n_beats < 3 && k < 50) begin cycle(); k++; end
    end
    check("rst2 reached beat 3", 64'(n_beats), 64'd3);
    reset = 1'b1;
    cycle();
    check("rst2 write",  64'(wr_master_write_o), 64'd0);
    check("rst2 rdreq",  64'(dma_wr_data_rdreq_o), 64'd0);
    check("rst2 busy",   64'(dma_wr_busy_o), 64'd0);
    check("rst2 done",   64'(dma_wr_done_o), 64'd0);
    check("rst2 bcount", 64'(wr_master_bcount_o), 64'd0);
    check("rst2 be",     64'(wr_master_byteenable_o), 64'd0);
    cycle();
    reset = 1'b0;
    flush_data();
    clear_stats();
    repeat (10) cycle();
    check("rst2 fifo emptied", 64'(dma_wr_busy_o), 64'd0);
    preload(2);
    push_cmd(16'd64, 32'h5000);
    wait_done(1, 100);
    repeat (4) cycle();
    check("rst2 new done", 64'(n_done), 64'd1);
    check("rst2 new beats", 64'(n_beats), 64'd2);
    check("rst2 new addr", 64'((b_addr.size() > 0) ? b_addr[0] : 32'hDEAD_BEEF), 64'h5000);
    check("rst2 new bcount", 64'((b_cnt.size() > 0) ? b_cnt[0] : 11'h7FF), 64'd2);
    check("rst2 new data", 64'(n_data_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_write_block.md
Name: dma_write_block

Overview:
Write-side counterpart of the DMA read path. It accepts write commands (destination address, byte count) from the descriptor processor into an internal command FIFO. It drains 256-bit data beats from the DMA data FIFO and issues Avalon-MM burst writes on the write master port. Commands longer than MAX_BURST_BEATS are split into consecutive bursts.

Parameters:
MAX_BURST_BEATS, 256, maximum beats per AVMM burst (1..2047)
CMD_FIFO_DEPTH, 32, command FIFO depth in entries (power of 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
dma_wr_fifo_command_req_i  input  1  push command into command FIFO
dma_wr_bytes_to_transfer_i  input  16  command byte count
dma_wr_addr_i  input  32  command destination byte address (32-byte aligned)
dma_wr_fifo_full_o  output  1  command FIFO full
dma_wr_data_i  input  256  head word of DMA data FIFO (show-ahead)
dma_wr_data_empty_i  input  1  DMA data FIFO empty
dma_wr_data_rdreq_o  output  1  pop DMA data FIFO
wr_master_addr_o  output  32  AVMM burst start address
wr_master_bcount_o  output  11  AVMM burstcount
wr_master_write_o  output  1  AVMM write
wr_master_data_o  output  256  AVMM writedata
wr_master_byteenable_o  output  32  AVMM byteenable
wr_master_wait_req_i  input  1  AVMM waitrequest
dma_wr_done_o  output  1  one-cycle pulse per completed command
dma_wr_busy_o  output  1  high from command pop until done pulse

Behaviour:
- Reset: all outputs 0 except dma_wr_fifo_full_o (0, FIFO empty). Command FIFO cleared, FSM to IDLE. Reset mid-burst drops wr_master_write_o on the next edge and abandons the burst. The data FIFO is not flushed by this block.
- Command FIFO: push on command_req when not full. A push while full is ignored and the FIFO contents are unchanged. Full is asserted when CMD_FIFO_DEPTH entries are held. A push and a pop in the same cycle are both honoured.
- FSM states:
  - IDLE: go to RD_CMD if the FIFO is not empty.
  - RD_CMD: pop one entry.
  - LD_CMD: latch addr, total beats = bytes[15:5] + |bytes[4:0] (12-bit), and tail = bytes[4:0]. If total beats = 0, go to DONE; else go to SETUP.
  - SETUP: burst beats = min(remaining, MAX_BURST_BEATS). Register wr_master_addr_o and wr_master_bcount_o. Go to BURST.
  - BURST: transfer beats; after the final beat of the burst is accepted, go to NEXT.
  - NEXT: addr += burst beats*32; remaining -= burst beats. If remaining = 0, go to DONE; else go to SETUP.
  - DONE: dma_wr_done_o = 1 for exactly this cycle, then go to IDLE.
- BURST handshake:
  - wr_master_write_o = ~dma_wr_data_empty_i while beats remain in the burst.
  - A beat is accepted when write & ~wait_req.
  - dma_wr_data_rdreq_o = write & ~wait_req, combinational.
  - wr_master_data_o = dma_wr_data_i.
  - Deasserting write mid-burst on data-FIFO empty is legal.
  - addr and bcount are held constant for the whole burst.
- Byteenable: all ones on every beat except the last beat of the last burst of a command with tail != 0. That beat uses (1<<tail)-1.
- Busy: set in RD_CMD, cleared after DONE.
- Latency: data FIFO non-empty with command queued → first write asserted 4 cycles after the command becomes visible (IDLE→RD_CMD→LD_CMD→SETUP→BURST).
- No read or write of the data FIFO outside BURST.

Test Plan:
- Push {bytes=64, addr=0x1000}, data FIFO preloaded, wait_req=0 → one burst: addr 0x1000, bcount 2, two write beats, byteenable 0xFFFFFFFF on both, done pulse once.
- bytes=100 → bcount 4. Byteenable 0xFFFFFFFF on beats 0-2 and 0x0000000F on beat 3. Exactly 4 rdreq pulses.
- bytes=40000, addr=0, MAX_BURST_BEATS=256 → bursts of 256,256,256,256,226 beats at addrs 0x0, 0x2000, 0x4000, 0x6000, 0x8000. Single done pulse at the end.
- wait_req held high for 5 cycles mid-burst plus data FIFO empty for 3 cycles → no beat lost or duplicated. addr/bcount stable, rdreq only on accepted beats, data order preserved.
- Push 33 commands with FSM blocked (data FIFO empty) → full asserts after 32. The 33rd command is dropped; 32 done pulses follow once data flows. A bytes=0 command gives a done pulse with no write.
- Assert reset during beat 3 of an 8-beat burst → write_o, rdreq, busy = 0 next cycle; command FIFO empty. A new command after reset completes normally.
